// File: rtl/icache_assoc.sv
// icache_assoc: read-only N-way set-associative instruction cache.
// Refills a whole line one word at a time over a valid/ready memory port.
// Replacement uses the lowest invalid way, otherwise a per-set round-robin
// pointer. The flush pulse invalidates every line. Write requests and
// misaligned requests are answered with an error response.
// Optional feature: define ICACHE_STATS_EN to add the hit_cnt/miss_cnt outputs.
//
// Handshakes: a CPU request is accepted on a rising edge where cpu_req_valid
// and cpu_req_ready are both high and flush is low. cpu_resp_valid is a
// one-cycle pulse with no backpressure. A memory request transfers on an edge
// where mem_req_valid and mem_req_ready are both high. mem_req_valid and
// mem_req_addr hold steady until that edge. mem_resp_valid is only consumed
// while the cache is waiting for a read.
module icache_assoc #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WAYS           = 2,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic              cpu_req_wr,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_data,
    output logic              cpu_resp_err,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {IDLE, RESP, MREQ, MWAIT, FILL} state_t;
    state_t state;

    // Line storage. Tags and data carry no reset because valid bits guard them.
    logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
    logic [DATA_W-1:0] data_q [WAYS][SETS*WORDS_PER_LINE];
    logic [SETS-1:0]   valid_q[WAYS];
    logic [WAY_W-1:0]  rr_ptr [SETS];

    // Latched request and refill context
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [OFF_W-1:0]  cnt;
    logic [WAY_W-1:0]  victim;
    logic [DATA_W-1:0] fill_word;
    logic              flush_pending;

    // Fields of the incoming request address
    logic [TAG_W-1:0]  in_tag;
    logic [IDX_W-1:0]  in_idx;
    logic [OFF_W-1:0]  in_off;
    logic              illegal;
    assign in_tag  = cpu_req_addr[ADDR_W-1 -: TAG_W];
    assign in_idx  = cpu_req_addr[2+OFF_W +: IDX_W];
    assign in_off  = cpu_req_addr[2 +: OFF_W];
    assign illegal = cpu_req_wr || (cpu_req_addr[1:0] != 2'b00);

    // The refill address is built from registers, so it stays stable during MREQ.
    assign mem_req_addr = {req_tag, req_idx, cnt, 2'b00};

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              has_free;
    logic [WAY_W-1:0]  free_way;
    logic [WAY_W-1:0]  new_victim;
    logic [DATA_W-1:0] hit_data;

    // Tag lookup and victim choice for the presented address
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[w][in_idx] && (tag_q[w][in_idx] == in_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!has_free && !valid_q[w][in_idx]) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        new_victim = has_free ? free_way : rr_ptr[in_idx];
    end

    assign hit_data = data_q[hit_way][{in_idx, in_off}];

    // Refill data and tag writes into the chosen victim way
    always_ff @(posedge clk) begin
        if (state == MWAIT && mem_resp_valid) begin
            data_q[victim][{req_idx, cnt}] <= mem_resp_data;
        end
        if (state == FILL) begin
            tag_q[victim][req_idx] <= req_tag;
        end
    end

    // Main controller: request handling, refill sequencing, valid bits and flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cpu_req_ready  <= 1'b1;
            cpu_resp_valid <= 1'b0;
            cpu_resp_data  <= '0;
            cpu_resp_err   <= 1'b0;
            mem_req_valid  <= 1'b0;
            req_tag        <= '0;
            req_idx        <= '0;
            req_off        <= '0;
            cnt            <= '0;
            victim         <= '0;
            fill_word      <= '0;
            flush_pending  <= 1'b0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                    end else if (cpu_req_valid && cpu_req_ready) begin
                        req_tag       <= in_tag;
                        req_idx       <= in_idx;
                        req_off       <= in_off;
                        cpu_req_ready <= 1'b0;
                        if (illegal) begin
                            cpu_resp_valid <= 1'b1;
                            cpu_resp_err   <= 1'b1;
                            cpu_resp_data  <= '0;
                            state          <= RESP;
                        end else if (hit) begin
                            cpu_resp_valid <= 1'b1;
                            cpu_resp_err   <= 1'b0;
                            cpu_resp_data  <= hit_data;
                            state          <= RESP;
                        end else begin
                            // The victim line is dropped now so no partial line is ever valid.
                            victim                     <= new_victim;
                            valid_q[new_victim][in_idx] <= 1'b0;
                            cnt                        <= '0;
                            mem_req_valid              <= 1'b1;
                            state                      <= MREQ;
                        end
                    end
                end
                RESP: begin
                    cpu_resp_valid <= 1'b0;
                    cpu_resp_err   <= 1'b0;
                    cpu_resp_data  <= '0;
                    cpu_req_ready  <= 1'b1;
                    state          <= IDLE;
                    // A flush seen during the transaction takes effect on the way back to IDLE.
                    if (flush || flush_pending) begin
                        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
                        flush_pending <= 1'b0;
                    end
                end
                MREQ: begin
                    if (flush) flush_pending <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= MWAIT;
                    end
                end
                MWAIT: begin
                    if (flush) flush_pending <= 1'b1;
                    if (mem_resp_valid) begin
                        if (cnt == req_off) fill_word <= mem_resp_data;
                        if (cnt == LAST_WORD) begin
                            state <= FILL;
                        end else begin
                            cnt           <= cnt + 1'b1;
                            mem_req_valid <= 1'b1;
                            state         <= MREQ;
                        end
                    end
                end
                FILL: begin
                    if (flush) flush_pending <= 1'b1;
                    valid_q[victim][req_idx] <= 1'b1;
                    rr_ptr[req_idx]          <= (rr_ptr[req_idx] == LAST_WAY) ? '0 : rr_ptr[req_idx] + 1'b1;
                    cpu_resp_valid           <= 1'b1;
                    cpu_resp_err             <= 1'b0;
                    cpu_resp_data            <= fill_word;
                    state                    <= RESP;
                end
                default: begin
                    state         <= IDLE;
                    cpu_req_ready <= 1'b1;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    // Count legal hits and misses in their accept cycle; flush clears both counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (flush) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE && cpu_req_valid && cpu_req_ready && !illegal) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc with WAYS=2, SETS=4 and WORDS_PER_LINE=4.
// The memory model returns addr ^ 0xA5A5A5A5 one cycle after each accepted request.
module tb_icache_assoc;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_wr;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic        cpu_resp_err;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  // memory model state
  logic        m_resp_valid;
  logic [31:0] m_resp_data;
  logic        s_valid;
  logic        hold_ready;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] mem_log[$];
  logic [31:0] exp_q[$];

  int total;
  int bad;

  assign mem_resp_valid = m_resp_valid | s_valid;
  assign mem_resp_data  = s_valid ? 32'hDEADBEEF : m_resp_data;

  icache_assoc #(
    .ADDR_W(32), .DATA_W(32), .WAYS(2), .SETS(4), .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wr(cpu_req_wr),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
    .cpu_resp_err(cpu_resp_err), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // memory responder: driven on negedges, one read outstanding
  initial begin
    mem_req_ready = 0;
    m_resp_valid  = 0;
    m_resp_data   = 0;
    pend          = 0;
    pend_addr     = 0;
    forever begin
      @(negedge clk);
      m_resp_valid = 0;
      if (pend) begin
        m_resp_valid = 1;
        m_resp_data  = pend_addr ^ 32'hA5A5A5A5;
        pend         = 0;
      end
      mem_req_ready = !hold_ready;
      if (mem_req_valid && mem_req_ready && !rst) begin
        mem_log.push_back(mem_req_addr);
        pend      = 1;
        pend_addr = mem_req_addr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    cpu_req_valid = 0;
    cpu_req_addr  = 0;
    cpu_req_wr    = 0;
    flush         = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  // drive one request until accepted; returns on the negedge after acceptance
  task automatic send_req(input logic [31:0] a, input logic w);
    int n;
    n = 0;
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    mem_log = {};
    cpu_req_valid = 1;
    cpu_req_addr  = a;
    cpu_req_wr    = w;
    @(negedge clk);
    cpu_req_valid = 0;
    cpu_req_wr    = 0;
  endtask

  // wait for the response pulse; optionally pulse flush in MWAIT of word flush_word
  task automatic wait_resp(input int flush_word, output logic [31:0] d, output logic e,
                           output int lat, output logic tail);
    logic flushed;
    flushed = 0;
    lat = 1;
    while (!cpu_resp_valid && lat < 300) begin
      if (flush_word >= 0 && !flushed && mem_log.size() == flush_word + 1 && !mem_req_valid) begin
        flush   = 1;
        flushed = 1;
      end else begin
        flush = 0;
      end
      @(negedge clk);
      lat++;
    end
    flush = 0;
    d = cpu_resp_valid ? cpu_resp_data : 32'hXXXXXXXX;
    e = cpu_resp_err;
    if (!cpu_resp_valid) lat = -1;
    @(negedge clk);
    tail = cpu_resp_valid;
  endtask

  task automatic fetch(input logic [31:0] a, input logic w, input int flush_word,
                       output logic [31:0] d, output logic e, output int lat, output logic tail);
    send_req(a, w);
    wait_resp(flush_word, d, e, lat, tail);
  endtask

  // scoreboard for line refills: four word reads in order from the line base
  task automatic check_reads(input string tag, input logic [31:0] base);
    logic [31:0] got;
    exp_q = {};
    for (int i = 0; i < 4; i++) exp_q.push_back(base + 32'(i * 4));
    check($sformatf("%s_nreads", tag), 32'(mem_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (i < mem_log.size()) ? mem_log[i] : 32'hFFFFFFFF;
      check($sformatf("%s_read%0d", tag, i), got, exp_q.pop_front());
    end
  endtask

  logic [31:0] d;
  logic        e;
  logic        tail;
  int          lat;
  int          n;

  initial begin
    total = 0;
    bad = 0;
    s_valid = 0;
    hold_ready = 0;
    rst = 1;
    cpu_req_valid = 0;
    cpu_req_addr = 0;
    cpu_req_wr = 0;
    flush = 0;

    // reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", cpu_req_ready, 1);
    check("rst_resp_valid", cpu_resp_valid, 0);
    check("rst_resp_err", cpu_resp_err, 0);
    check("rst_resp_data", cpu_resp_data, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_mem_addr", mem_req_addr, 0);
    rst = 0;
    @(negedge clk);

    // cold miss, then hit in the same line
    fetch(32'h108, 0, -1, d, e, lat, tail);
    check_reads("cold108", 32'h100);
    check("cold108_data", d, 32'hA5A5A4AD);
    check("cold108_err", e, 0);
    check("cold108_tail", tail, 0);
    fetch(32'h10C, 0, -1, d, e, lat, tail);
    check("hit10c_lat", lat, 1);
    check("hit10c_data", d, 32'hA5A5A4A9);
    check("hit10c_err", e, 0);
    check("hit10c_nreads", 32'(mem_log.size()), 0);
    check("hit10c_tail", tail, 0);

    // replacement in set 0
    do_reset();
    fetch(32'h100, 0, -1, d, e, lat, tail);
    check_reads("rep100", 32'h100);
    check("rep100_data", d, 32'hA5A5A4A5);
    fetch(32'h200, 0, -1, d, e, lat, tail);
    check_reads("rep200", 32'h200);
    check("rep200_data", d, 32'hA5A5A7A5);
    fetch(32'h300, 0, -1, d, e, lat, tail);
    check_reads("rep300", 32'h300);
    check("rep300_data", d, 32'hA5A5A6A5);
    fetch(32'h200, 0, -1, d, e, lat, tail);
    check("rep200hit_lat", lat, 1);
    check("rep200hit_nreads", 32'(mem_log.size()), 0);
    check("rep200hit_data", d, 32'hA5A5A7A5);
    fetch(32'h100, 0, -1, d, e, lat, tail);
    check_reads("rep100b", 32'h100);
    fetch(32'h304, 0, -1, d, e, lat, tail);
    check("rep304hit_nreads", 32'(mem_log.size()), 0);
    check("rep304hit_data", d, 32'hA5A5A6A1);
    fetch(32'h204, 0, -1, d, e, lat, tail);
    check_reads("rep204miss", 32'h200);
    check("rep204miss_data", d, 32'hA5A5A7A1);

    // illegal requests
    fetch(32'h102, 0, -1, d, e, lat, tail);
    check("mis_lat", lat, 1);
    check("mis_err", e, 1);
    check("mis_data", d, 0);
    check("mis_nreads", 32'(mem_log.size()), 0);
    fetch(32'h100, 1, -1, d, e, lat, tail);
    check("wr_lat", lat, 1);
    check("wr_err", e, 1);
    check("wr_data", d, 0);
    check("wr_nreads", 32'(mem_log.size()), 0);

    // flush in IDLE blocks a same-cycle request and drops cached lines
    mem_log = {};
    flush = 1;
    cpu_req_valid = 1;
    cpu_req_addr = 32'h100;
    @(negedge clk);
    flush = 0;
    cpu_req_valid = 0;
    check("iflush_no_resp", cpu_resp_valid, 0);
    check("iflush_no_mem", mem_req_valid, 0);
    @(negedge clk);
    check("iflush_no_resp2", cpu_resp_valid, 0);
    check("iflush_ready", cpu_req_ready, 1);
    fetch(32'h100, 0, -1, d, e, lat, tail);
    check_reads("iflush100", 32'h100);

    // flush during refill of word 2
    do_reset();
    fetch(32'h100, 0, -1, d, e, lat, tail);
    fetch(32'h408, 0, 2, d, e, lat, tail);
    check_reads("mflush408", 32'h400);
    check("mflush408_data", d, 32'hA5A5A1AD);
    check("mflush408_err", e, 0);
    fetch(32'h408, 0, -1, d, e, lat, tail);
    check_reads("mflush408b", 32'h400);
    fetch(32'h100, 0, -1, d, e, lat, tail);
    check_reads("mflush100", 32'h100);

    // reset in MWAIT, then a stale memory response
    send_req(32'h500, 0);
    n = 0;
    while (!(mem_log.size() == 2 && !mem_req_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rmid_reached", 32'(n < 100), 1);
    rst = 1;
    #1;
    check("rmid_mem_valid", mem_req_valid, 0);
    check("rmid_ready", cpu_req_ready, 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    check("stale_resp_valid", cpu_resp_valid, 0);
    check("stale_mem_valid", mem_req_valid, 0);
    @(negedge clk);
    check("stale_resp_valid2", cpu_resp_valid, 0);
    check("stale_ready", cpu_req_ready, 1);
    fetch(32'h500, 0, -1, d, e, lat, tail);
    check_reads("rmid500", 32'h500);
    check("rmid500_data", d, 32'hA5A5A0A5);

    // memory backpressure for 5 cycles
    hold_ready = 1;
    send_req(32'h600, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_valid", i), mem_req_valid, 1);
      check($sformatf("stall%0d_addr", i), mem_req_addr, 32'h600);
      check($sformatf("stall%0d_ready", i), cpu_req_ready, 0);
      @(negedge clk);
    end
    hold_ready = 0;
    wait_resp(-1, d, e, lat, tail);
    check_reads("stall600", 32'h600);
    check("stall600_data", d, 32'hA5A5A3A5);
    fetch(32'h604, 0, -1, d, e, lat, tail);
    check("hit604_nreads", 32'(mem_log.size()), 0);
    check("hit604_data", d, 32'hA5A5A3A1);
`ifdef ICACHE_STATS_EN
    check("stats_hit", hit_cnt, 1);
    check("stats_miss", miss_cnt, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised, read-only, N-way set-associative instruction cache between the fetch stage and the instruction memory port.
- Successor to the single-configuration I-cache: configurable ways, sets and line length, with multi-word line refill over a valid/ready memory handshake.
- Adds round-robin replacement, a whole-cache flush and error responses for illegal requests.

Parameters:
- ADDR_W, 32, CPU/memory byte-address width
- DATA_W, 32, word width; fixed at 32 in this generation (byte offset = 2 bits)
- WAYS, 2, associativity; power of two, 1..8
- SETS, 16, sets per way; power of two, >=2
- WORDS_PER_LINE, 4, words per line; power of two, >=2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req_valid  in  1  fetch request valid
- cpu_req_ready  out  1  cache can accept a request this cycle
- cpu_req_addr  in  ADDR_W  byte address
- cpu_req_wr  in  1  write request (illegal, answered with error)
- cpu_resp_valid  out  1  single-cycle response pulse; no backpressure
- cpu_resp_data  out  DATA_W  instruction word
- cpu_resp_err  out  1  response is an error
- flush  in  1  invalidate all lines (single-cycle pulse)
- mem_req_valid  out  1  memory read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  word-aligned read address
- mem_resp_valid  in  1  read data valid (at least 1 cycle after request accept)
- mem_resp_data  in  DATA_W  read data

Behaviour:
- Address split: [1:0] byte, then log2(WORDS_PER_LINE) word select, then log2(SETS) index, remaining high bits tag.
- Storage: tags, valid bits and data held in flops/array. Per-set round-robin victim pointer.
- Reset (async): all valid bits, victim pointers and flush_pending = 0; state IDLE; all outputs 0 except cpu_req_ready = 1.
- FSM states: IDLE, RESP, MREQ, MWAIT, FILL.
- IDLE:
  - cpu_req_ready = !flush_pending.
  - On accept: latch the address.
  - Illegal request (cpu_req_wr = 1 or addr[1:0] != 0): go to RESP with err = 1, data = 0, no memory traffic.
  - Hit (any valid way with matching tag): go to RESP with the word.
  - Miss: go to MREQ with word counter = 0.
- RESP: cpu_resp_valid = 1 for exactly one cycle (data/err registered), then IDLE. Hit latency = 1 cycle after accept.
- MREQ:
  - mem_req_valid = 1, mem_req_addr = {tag, index, counter, 2'b00}.
  - Refill is line-aligned, word 0 first.
  - mem_req_valid and mem_req_addr stay stable until mem_req_ready, then MWAIT.
- MWAIT:
  - On mem_resp_valid: write the word into the victim way (chosen at miss time).
  - If counter = WORDS_PER_LINE-1, go to FILL; else counter+1 and back to MREQ.
  - Exactly one outstanding memory read at a time.
- FILL:
  - Set the tag, set the valid bit, advance the set's victim pointer (mod WAYS).
  - Present the requested word in RESP next cycle.
- Victim choice: lowest-index invalid way if one exists; otherwise the round-robin pointer.
- cpu_req_ready = 0 in every state except IDLE.
- Flush:
  - In IDLE: clears all valid bits at the next edge. A request presented in the same cycle is not accepted.
  - In any other state: latched into flush_pending. The pending miss still completes and responds. All lines, including the one just filled, are invalidated on the cycle the FSM re-enters IDLE.
- mem_resp_valid seen outside MWAIT is ignored. This covers stale data after a reset mid-refill.
- Reset mid-refill: immediate abort, no partial line left valid, mem_req_valid drops asynchronously.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Incremented in the accept cycle of legal hits and misses respectively; illegal requests are not counted.
  - Both cleared by rst and by flush.
  - Wrap from 0xFFFFFFFF to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- WAYS=2, SETS=4, WORDS=4; memory returns data = addr ^ 0xA5A5A5A5.
  - Fetch 0x108 (cold) -> 4 mem reads 0x100, 0x104, 0x108, 0x10C in order -> resp data 0xA5A5A4AD, err 0.
  - Refetch 0x10C -> resp 1 cycle after accept, no mem_req_valid.
- Fill set 0 with 0x100 and 0x200, then fetch 0x300 -> evicts way 0 (the 0x100 line).
  - Fetch 0x200 -> hit.
  - Fetch 0x100 -> miss, refill into way 1.
- Request 0x102 and a request with cpu_req_wr = 1 -> each gives cpu_resp_valid with err 1, data 0, no memory traffic.
- Pulse flush while in MWAIT on the word-2 read -> miss completes with correct data.
  - A subsequent fetch of the same address misses again (4 mem reads).
- Assert rst while in MWAIT, then drive a stale mem_resp_valid -> ignored.
  - Re-fetch of the same line misses cleanly with 4 fresh reads.
- Hold mem_req_ready low 5 cycles -> mem_req_valid/mem_req_addr stable throughout, cpu_req_ready = 0.
  - With ICACHE_STATS_EN, after the above: hit_cnt/miss_cnt match the scoreboard.
